// File: rtl/uart_frame_decoder_if.sv
// Byte-stream input and operand/status outputs of uart_frame_decoder.
// err_count/err_clr exist only when UART_FRAME_ERR_CNT_EN is defined.
interface uart_frame_decoder_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [1:0]  s;
  logic [15:0] R_vertical_1;
  logic [15:0] R_vertical_2;
  logic [15:0] R_horizontal_1;
  logic [15:0] R_horizontal_2;
  logic [15:0] theta_manual;
  logic [15:0] theta_actual;
  logic [15:0] phi_manual;
  logic [15:0] phi_actual;
  logic        frame_ok;
  logic        frame_err;
`ifdef UART_FRAME_ERR_CNT_EN
  logic [7:0]  err_count;
  logic        err_clr;
`endif

  modport master (
    output rx_data, rx_valid,
    input  s, R_vertical_1, R_vertical_2, R_horizontal_1, R_horizontal_2,
           theta_manual, theta_actual, phi_manual, phi_actual, frame_ok, frame_err
`ifdef UART_FRAME_ERR_CNT_EN
    , input err_count, output err_clr
`endif
  );

  modport slave (
    input  rx_data, rx_valid,
    output s, R_vertical_1, R_vertical_2, R_horizontal_1, R_horizontal_2,
           theta_manual, theta_actual, phi_manual, phi_actual, frame_ok, frame_err
`ifdef UART_FRAME_ERR_CNT_EN
    , output err_count, input err_clr
`endif
  );
endinterface

// File: rtl/uart_frame_decoder.sv
// Parses SOF, MODE, 16 operand bytes, XOR CHK; commits mode and operands atomically on a good frame.
// Optional saturating frame-error counter when UART_FRAME_ERR_CNT_EN is defined.
module uart_frame_decoder #(
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input logic                 clk,
  input logic                 rst_n,
  uart_frame_decoder_if.slave bus
);
  localparam int            CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MODE, DATA, CHECK} state_t;

  state_t        state;
  logic [CW-1:0] tcnt;
  logic [3:0]    idx;
  logic [7:0]    xor_acc;
  logic [1:0]    mode_sh;
  logic [127:0]  data_sh;
  logic [1:0]    s_q;
  logic [127:0]  ops_q;
  logic          ok_q;
  logic          err_q;
  logic          expire;
  logic          chk_bad;

  // A byte arriving in the expiry cycle takes precedence over the abort.
  assign expire  = (state != IDLE) && !bus.rx_valid && (tcnt == TLIM);
  assign chk_bad = (state == CHECK) && bus.rx_valid && (bus.rx_data != xor_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tcnt    <= '0;
      idx     <= '0;
      xor_acc <= '0;
      mode_sh <= '0;
      data_sh <= '0;
      s_q     <= '0;
      ops_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ok_q  <= 1'b0;
      err_q <= 1'b0;
      if (state == IDLE || bus.rx_valid) begin
        tcnt <= '0;
      end else if (tcnt != TLIM) begin
        tcnt <= tcnt + 1'b1;
      end

      if (expire) begin
        state <= IDLE;
        err_q <= 1'b1;
      end else if (bus.rx_valid) begin
        case (state)
          IDLE: begin
            if (bus.rx_data == SOF_BYTE) begin
              state   <= MODE;
              xor_acc <= '0;
            end
          end
          MODE: begin
            mode_sh <= bus.rx_data[1:0];
            xor_acc <= xor_acc ^ bus.rx_data;
            idx     <= '0;
            state   <= DATA;
          end
          DATA: begin
            // Shadow is a shift register: after 16 bytes it holds the operands MSB-first in port order.
            data_sh <= {data_sh[119:0], bus.rx_data};
            xor_acc <= xor_acc ^ bus.rx_data;
            idx     <= idx + 4'd1;
            if (idx == 4'd15) begin
              state <= CHECK;
            end
          end
          CHECK: begin
            if (chk_bad) begin
              err_q <= 1'b1;
            end else begin
              s_q   <= mode_sh;
              ops_q <= data_sh;
              ok_q  <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.s              = s_q;
  assign bus.R_vertical_1   = ops_q[127:112];
  assign bus.R_vertical_2   = ops_q[111:96];
  assign bus.R_horizontal_1 = ops_q[95:80];
  assign bus.R_horizontal_2 = ops_q[79:64];
  assign bus.theta_manual   = ops_q[63:48];
  assign bus.theta_actual   = ops_q[47:32];
  assign bus.phi_manual     = ops_q[31:16];
  assign bus.phi_actual     = ops_q[15:0];
  assign bus.frame_ok       = ok_q;
  assign bus.frame_err      = err_q;

`ifdef UART_FRAME_ERR_CNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (bus.err_clr) begin
      err_cnt <= '0;
    end else if ((expire || chk_bad) && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign bus.err_count = err_cnt;
`endif
endmodule

// File: doc/uart_frame_decoder.md
Name: uart_frame_decoder

Overview:
- Upstream stage of control_movimiento: turns the UART receiver's byte stream into the mode select and the eight 16-bit operands that the motion controller consumes.
- Parses one fixed-length frame, checks an XOR checksum, and commits all outputs atomically on a good frame.
- Replaces the hard-coded operand values used today with operands loaded from the host over the serial link.

Parameters:
- SOF_BYTE, 8'hA5, start-of-frame marker.
- TIMEOUT_CYCLES, 100000, maximum idle clocks between two bytes of one frame before the frame is aborted.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_data  input  8  received byte from the UART receiver.
- rx_valid  input  1  one-cycle strobe; rx_data is valid while high.
- s  output  2  mode select to control_movimiento.
- R_vertical_1, R_vertical_2, R_horizontal_1, R_horizontal_2  output  16 each  sensor operands.
- theta_manual, theta_actual, phi_manual, phi_actual  output  16 each  angle operands.
- frame_ok  output  1  one-cycle pulse: outputs were just updated.
- frame_err  output  1  one-cycle pulse: frame rejected (bad checksum or timeout).

Behaviour:
- Reset:
  - Asynchronous on rst_n low.
  - All operand outputs, s, frame_ok and frame_err go to 0.
  - FSM goes to IDLE; shadow registers, byte index and timeout counter clear.
- Frame format, 19 bytes:
  - SOF_BYTE.
  - MODE byte; bits [1:0] go to s, bits [7:2] are ignored but included in the checksum.
  - 16 data bytes, MSB first, in this order: R_vertical_1, R_vertical_2, R_horizontal_1, R_horizontal_2, theta_manual, theta_actual, phi_manual, phi_actual.
  - CHK byte = XOR of MODE and the 16 data bytes.
- FSM states: IDLE, MODE, DATA, CHECK.
  - IDLE: on rx_valid with rx_data==SOF_BYTE go to MODE and clear the running XOR. Any other byte is ignored, with no error.
  - MODE: on rx_valid latch the byte into shadow, XOR it in, set index=0, go to DATA.
  - DATA: on rx_valid write the byte into shadow[index], XOR it in, increment index. After index 15 go to CHECK. A byte equal to SOF_BYTE is treated as data.
  - CHECK: on rx_valid compare the byte with the running XOR.
    - Equal: copy all shadow registers to the outputs and pulse frame_ok on the next edge.
    - Unequal: keep the outputs unchanged and pulse frame_err.
    - Either way, return to IDLE.
- Latency: outputs and frame_ok change on the clock edge after the CHK byte's rx_valid cycle. All outputs update in the same cycle; there are no partial updates.
- Timeout:
  - The counter clears on every rx_valid and in IDLE, and otherwise increments.
  - When it reaches TIMEOUT_CYCLES-1 in any non-IDLE state: go to IDLE, pulse frame_err, keep outputs unchanged.
  - If rx_valid and timeout expiry coincide, the byte wins and the counter clears.
- Counter width is $clog2(TIMEOUT_CYCLES). The counter does not wrap past the limit.
- frame_ok and frame_err are never high in the same cycle. Both are low when not pulsing.
- A reset in the middle of a frame discards the partial frame. The next frame needs a fresh SOF.
- Back-to-back frames are supported: a SOF may arrive in the cycle right after CHK.

Optional Feature:
- Macro: UART_FRAME_ERR_CNT_EN.
- Defined:
  - Adds output port err_count [7:0], reset to 0.
  - Increments on every frame_err pulse and saturates at 255.
  - Adds input err_clr, which clears it synchronously; when err_clr and an error coincide, err_clr wins.
- Undefined: no port, no counter; all other behaviour is identical.

Test Plan:
- Good frame:
  - Stimulus: A5, 01, 00 14, 00 1E, 00 05, 00 0F, 00 03, 00 05, 00 04, 00 02, CHK=0x01^0x14^0x1E^0x05^0x0F^0x03^0x05^0x04^0x02.
  - Response: s=1, R_vertical_1=20, R_vertical_2=30, R_horizontal_1=5, R_horizontal_2=15, theta_manual=3, theta_actual=5, phi_manual=4, phi_actual=2; one frame_ok pulse.
- Bad checksum:
  - Stimulus: the same frame with CHK xor 0x01.
  - Response: frame_err pulses; outputs keep their prior values; frame_ok stays 0.
- Timeout:
  - Stimulus: A5, 02, 3 data bytes, then silence for TIMEOUT_CYCLES clocks; then a full good frame with mode 02.
  - Response: frame_err at the timeout; outputs unchanged until the good frame's frame_ok; then s=2.
- Noise and in-payload SOF:
  - Stimulus: 00 FF 33 before a frame; a frame whose data contains A5 bytes.
  - Response: no error from the leading bytes; A5 bytes inside the payload are loaded as data; frame_ok.
- Reset mid-frame:
  - Stimulus: assert rst_n low after 8 bytes of a frame.
  - Response: all outputs 0 immediately, with no frame_ok or frame_err. A later good frame is accepted.
- With UART_FRAME_ERR_CNT_EN defined:
  - Stimulus: 300 bad-checksum frames, then err_clr, then 1 bad frame.
  - Response: err_count saturates at 255, clears to 0 on err_clr, then reads 1.
